// File: rtl/mem_wb_stage_if.sv
// Bundles the MEM->WB handshake, entry payload, forwarding port and counters
// of mem_wb_stage; clk and reset stay as plain ports on the stage.
interface mem_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ReadData;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] pcplus1;
  logic [REG_AW-1:0] destreg;
  logic              RegWrite;
  logic [1:0]        ResultSrc;
  logic              is_matrix_mult;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] WBResult;
  logic [REG_AW-1:0] destreg_out;
  logic              RegWrite_out;
  logic              is_matrix_mult_out;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retired_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output in_valid, ReadData, ALUResult, pcplus1, destreg, RegWrite,
           ResultSrc, is_matrix_mult, flush, out_ready,
    input  in_ready, out_valid, WBResult, destreg_out, RegWrite_out,
           is_matrix_mult_out, fwd_valid, fwd_reg, fwd_data,
           retired_count, stall_count
  );

  modport slave (
    input  in_valid, ReadData, ALUResult, pcplus1, destreg, RegWrite,
           ResultSrc, is_matrix_mult, flush, out_ready,
    output in_ready, out_valid, WBResult, destreg_out, RegWrite_out,
           is_matrix_mult_out, fwd_valid, fwd_reg, fwd_data,
           retired_count, stall_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 2-entry skid buffer (head + skid) with the result
// mux applied at capture, a forwarding port and saturating perf counters.
module mem_wb_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_stall;
  logic              w_load_head_in;
  logic              w_load_head_skid;
  logic              w_load_skid;
  logic [DATA_W-1:0] w_in_result;

  logic [DATA_W-1:0] r_head_result;
  logic [REG_AW-1:0] r_head_dest;
  logic              r_head_rw;
  logic              r_head_mm;
  logic [DATA_W-1:0] r_skid_result;
  logic [REG_AW-1:0] r_skid_dest;
  logic              r_skid_rw;
  logic              r_skid_mm;
  logic [CNT_W-1:0]  r_retired;
  logic [CNT_W-1:0]  r_stall;

  // Handshake flags decode registered state only, so in_ready never sees out_ready.
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_stall     = w_out_valid & ~bus.out_ready;

  always_comb begin
    w_in_result = bus.ALUResult;
    case (bus.ResultSrc)
      2'b01:   w_in_result = bus.ReadData;
      2'b10:   w_in_result = bus.pcplus1;
      default: w_in_result = bus.ALUResult;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_load_head_in = 1'b1;
            w_state_next   = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_head_in = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid  = 1'b1;
            w_state_next = S_FULL;
          end else if (w_out_fire) begin
            w_state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_load_head_skid = 1'b1;
            w_state_next     = S_ONE;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_result <= '0;
      r_head_dest   <= '0;
      r_head_rw     <= 1'b0;
      r_head_mm     <= 1'b0;
      r_skid_result <= '0;
      r_skid_dest   <= '0;
      r_skid_rw     <= 1'b0;
      r_skid_mm     <= 1'b0;
    end else begin
      if (w_load_head_in) begin
        r_head_result <= w_in_result;
        r_head_dest   <= bus.destreg;
        r_head_rw     <= bus.RegWrite;
        r_head_mm     <= bus.is_matrix_mult;
      end else if (w_load_head_skid) begin
        r_head_result <= r_skid_result;
        r_head_dest   <= r_skid_dest;
        r_head_rw     <= r_skid_rw;
        r_head_mm     <= r_skid_mm;
      end
      if (w_load_skid) begin
        r_skid_result <= w_in_result;
        r_skid_dest   <= bus.destreg;
        r_skid_rw     <= bus.RegWrite;
        r_skid_mm     <= bus.is_matrix_mult;
      end
    end
  end

  // Counters saturate and deliberately ignore flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
      r_stall   <= '0;
    end else begin
      if (w_out_fire && (r_retired != {CNT_W{1'b1}})) begin
        r_retired <= r_retired + 1'b1;
      end
      if (w_stall && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign bus.in_ready           = w_in_ready;
  assign bus.out_valid          = w_out_valid;
  assign bus.WBResult           = r_head_result;
  assign bus.destreg_out        = r_head_dest;
  assign bus.RegWrite_out       = w_out_valid & r_head_rw;
  assign bus.is_matrix_mult_out = r_head_mm;
  assign bus.fwd_valid          = w_out_valid & r_head_rw;
  assign bus.fwd_reg            = r_head_dest;
  assign bus.fwd_data           = r_head_result;
  assign bus.retired_count      = r_retired;
  assign bus.stall_count        = r_stall;

endmodule
